// File: rtl/clk_div_prog.sv
// Multi-channel programmable square-wave divider with per-channel rising-edge tick,
// valid/ready divisor reload at toggle boundaries and a global phase sync.
// Optional macro CLK_DIV_HOLD_EN: en=0 freezes a channel instead of clearing it.
module clk_div_prog #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DEFAULT_HALF = 25000000,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] pending_v;

  // Out-of-range cfg_ch matches no channel, so it reads ready and the write is dropped.
  always_comb begin
    cfg_ready = ~|(sel & pending_v);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(g);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] eff;
    logic             pending;
    logic             clk_q;
    logic             tick_q;
    logic             terminal;
    logic             accept;

    always_comb begin
      eff      = (half_q == '0) ? CNT_W'(1) : half_q;
      terminal = (count == eff - CNT_W'(1));
      accept   = cfg_valid && cfg_ready && sel[g];
    end

    assign sel[g]       = (cfg_ch == CH_ID);
    assign pending_v[g] = pending;
    assign clk_out[g]   = clk_q;
    assign tick[g]      = tick_q;

    // accept requires pending=0 and apply requires pending=1, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        count   <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        half_q  <= RST_HALF;
        shadow  <= RST_HALF;
        pending <= 1'b0;
      end else begin
        if (accept) begin
          shadow  <= cfg_half;
          pending <= 1'b1;
        end
        if (sync) begin
          count  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pending) begin
            half_q  <= shadow;
            pending <= 1'b0;
          end
        end else if (!en[g]) begin
`ifdef CLK_DIV_HOLD_EN
          tick_q <= 1'b0;
`else
          count  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pending) begin
            half_q  <= shadow;
            pending <= 1'b0;
          end
`endif
        end else if (terminal) begin
          count  <= '0;
          clk_q  <= ~clk_q;
          tick_q <= ~clk_q;
          if (pending) begin
            half_q  <= shadow;
            pending <= 1'b0;
          end
        end else begin
          count  <= count + CNT_W'(1);
          tick_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (CNT_W=8, NUM_CH=2, DEFAULT_HALF=4): vector table
// for free-run and reprogramming, plus hand sequences for half=0, sync, en, reset, max half.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] en = '0;
  logic       sync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ch = 1'b0;
  logic [7:0] cfg_half = '0;
  logic       cfg_ready;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int total = 0;
  int bad = 0;

  clk_div_prog #(
    .CNT_W(8),
    .NUM_CH(2),
    .DEFAULT_HALF(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync(sync),
    .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
    .cfg_ready(cfg_ready),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic       ch;
    logic [7:0] half;
    logic [1:0] eclk;
    logic [1:0] etick;
    logic       erdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic cv, input logic ch, input logic [7:0] half,
                     input logic [1:0] eclk, input logic [1:0] etick, input logic erdy);
    vec_t v;
    v.cv = cv; v.ch = ch; v.half = half; v.eclk = eclk; v.etick = etick; v.erdy = erdy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_half = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_clk", 32'(clk_out), 32'(2'b00));
    chk("rst_tick", 32'(tick), 32'(2'b00));
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(cfg_ready), 32'd1);
  endtask

  logic [1:0] c_clk [6];
  logic [1:0] c_tick[6];
  logic       d_clk [4];
  logic       d_tick[4];

  initial begin
    // e1..e30 after reset release, both channels enabled.
    for (int i = 1; i <= 3; i++) add(0, 1, 0, 2'b00, 2'b00, 1);
    add(0, 1, 0, 2'b11, 2'b11, 1);
    for (int i = 5; i <= 7; i++) add(0, 1, 0, 2'b11, 2'b00, 1);
    add(0, 1, 0, 2'b00, 2'b00, 1);
    add(0, 1, 0, 2'b00, 2'b00, 1);
    add(1, 1, 2, 2'b00, 2'b00, 1);
    add(0, 1, 0, 2'b00, 2'b00, 0);
    add(0, 1, 0, 2'b11, 2'b11, 0);
    add(0, 1, 0, 2'b11, 2'b00, 1);
    add(0, 1, 0, 2'b01, 2'b00, 1);
    add(0, 1, 0, 2'b01, 2'b00, 1);
    add(0, 1, 0, 2'b10, 2'b10, 1);
    add(0, 1, 0, 2'b10, 2'b00, 1);
    add(0, 1, 0, 2'b00, 2'b00, 1);
    add(0, 1, 0, 2'b00, 2'b00, 1);
    add(1, 0, 3, 2'b11, 2'b11, 1);
    add(0, 0, 0, 2'b11, 2'b00, 0);
    add(0, 0, 0, 2'b01, 2'b00, 0);
    add(0, 0, 0, 2'b01, 2'b00, 0);
    add(0, 0, 0, 2'b10, 2'b10, 0);
    add(0, 0, 0, 2'b10, 2'b00, 1);
    add(0, 0, 0, 2'b00, 2'b00, 1);
    add(0, 0, 0, 2'b01, 2'b01, 1);
    add(0, 0, 0, 2'b11, 2'b10, 1);
    add(0, 0, 0, 2'b11, 2'b00, 1);
    add(0, 0, 0, 2'b00, 2'b00, 1);

    do_reset();
    en = 2'b11;
    for (int i = 0; i < tbl.size(); i++) begin
      cfg_valid = tbl[i].cv;
      cfg_ch    = tbl[i].ch;
      cfg_half  = tbl[i].half;
      #1;
      chk($sformatf("tbl%0d_ready", i + 1), 32'(cfg_ready), 32'(tbl[i].erdy));
      cyc();
      chk($sformatf("tbl%0d_clk", i + 1), 32'(clk_out), 32'(tbl[i].eclk));
      chk($sformatf("tbl%0d_tick", i + 1), 32'(tick), 32'(tbl[i].etick));
    end
    cfg_valid = 1'b0;

    // half=0 on ch0: old half-period of 4 completes, then clk/2.
    do_reset();
    en = 2'b11;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd0;
    cyc();
    cfg_valid = 1'b0;
    #1;
    chk("h0_ready_low", 32'(cfg_ready), 32'd0);
    cyc();
    cyc();
    cyc();
    chk("h0_e4_clk", 32'(clk_out[0]), 32'd1);
    chk("h0_e4_tick", 32'(tick[0]), 32'd1);
    chk("h0_e4_ready", 32'(cfg_ready), 32'd1);
    for (int k = 5; k <= 8; k++) begin
      cyc();
      chk($sformatf("h0_e%0d_clk", k), 32'(clk_out[0]), 32'((k % 2) == 0));
      chk($sformatf("h0_e%0d_tick", k), 32'(tick[0]), 32'((k % 2) == 0));
    end

    // Program halves 3 and 5, then sync applies them and phase-aligns.
    do_reset();
    en = 2'b11;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd3;
    cyc();
    cfg_ch = 1'b1; cfg_half = 8'd5;
    #1;
    chk("sy_ready_ch1", 32'(cfg_ready), 32'd1);
    cyc();
    cfg_valid = 1'b0; sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sy_clk", 32'(clk_out), 32'(2'b00));
    chk("sy_tick", 32'(tick), 32'(2'b00));
    chk("sy_ready", 32'(cfg_ready), 32'd1);
    c_clk  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
    c_tick = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("sy_p%0d_clk", k + 1), 32'(clk_out), 32'(c_clk[k]));
      chk($sformatf("sy_p%0d_tick", k + 1), 32'(tick), 32'(c_tick[k]));
    end

    // Drop en[0] for 3 cycles with ch0 count at 2.
    do_reset();
    en = 2'b11;
    cyc();
    cyc();
    en = 2'b10;
    cyc();
    chk("en_off_clk", 32'(clk_out[0]), 32'd0);
    cyc();
    cyc();
    chk("en_off_tick", 32'(tick[0]), 32'd0);
    en = 2'b11;
`ifdef CLK_DIV_HOLD_EN
    d_clk  = '{1'b0, 1'b1, 1'b1, 1'b1};
    d_tick = '{1'b0, 1'b1, 1'b0, 1'b0};
`else
    d_clk  = '{1'b0, 1'b0, 1'b0, 1'b1};
    d_tick = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("en_on%0d_clk", k + 1), 32'(clk_out[0]), 32'(d_clk[k]));
      chk($sformatf("en_on%0d_tick", k + 1), 32'(tick[0]), 32'(d_tick[k]));
    end

    // Async reset mid-period with a pending write on ch1.
    do_reset();
    en = 2'b11;
    for (int k = 0; k < 4; k++) cyc();
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd2;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    chk("ar_pre_clk", 32'(clk_out), 32'(2'b11));
    chk("ar_pre_ready", 32'(cfg_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("ar_async_clk", 32'(clk_out), 32'(2'b00));
    chk("ar_async_ready", 32'(cfg_ready), 32'd1);
    cyc();
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("ar_e%0d_clk", k), 32'(clk_out), ((k / 4) % 2) == 1 ? 32'(2'b11) : 32'(2'b00));
    end

    // Maximum half-period 255 on ch1.
    do_reset();
    en = 2'b11;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd255;
    cyc();
    cfg_valid = 1'b0;
    for (int k = 2; k <= 514; k++) begin
      cyc();
      if (k == 4)   chk("mx_e4_clk", 32'(clk_out[1]), 32'd1);
      if (k == 258) chk("mx_e258_clk", 32'(clk_out[1]), 32'd1);
      if (k == 259) chk("mx_e259_clk", 32'(clk_out[1]), 32'd0);
      if (k == 513) chk("mx_e513_clk", 32'(clk_out[1]), 32'd0);
      if (k == 514) begin
        chk("mx_e514_clk", 32'(clk_out[1]), 32'd1);
        chk("mx_e514_tick", 32'(tick[1]), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel, runtime-programmable successor to the fixed 25 MHz-count divider.
- NUM_CH independent square-wave dividers share one clock.
- Each channel has its own half-period register, enable and one-cycle rising-edge tick.
- Divisors are reprogrammed through a valid/ready config port and take effect glitch-free at the next toggle boundary. A global sync input phase-aligns all channels.
- Feeds slow-clock enables (LED/debug stepping, predictor single-step) in the top level.

Parameters:
- CNT_W, 32, width of counters and half-period values.
- NUM_CH, 2, number of divider channels (1..16).
- DEFAULT_HALF, 25000000, reset half-period in clk cycles for every channel.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  restart all channels in phase.
- cfg_valid  in  1  config write request.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_half  in  CNT_W  new half-period in clk cycles.
- cfg_ready  out  1  config accept.
- clk_out  out  NUM_CH  divided square waves.
- tick  out  NUM_CH  one-cycle pulse coincident with each clk_out rise.

Behaviour:
- Reset (reset=0, async):
  - count=0, clk_out=0, tick=0.
  - half_q=DEFAULT_HALF, shadow=DEFAULT_HALF, pending=0.
  - cfg_ready reads 1 once reset is released.
- Effective half: eff = (half_q==0) ? 1 : half_q.
  - eff=1 gives a toggle every cycle, i.e. clk/2.
- Per channel, en=1, no sync:
  - count increments each cycle.
  - When count==eff-1: count<=0, clk_out<=~clk_out.
  - tick<=1 in the same cycle clk_out goes 0->1; otherwise tick<=0.
  - Output period = 2*eff clk cycles, 50% duty.
- Per channel, en=0: next cycle count<=0, clk_out<=0, tick<=0.
  - A pending config is applied immediately (half_q<=shadow, pending<=0).
- Config handshake:
  - cfg_ready = ~pending[cfg_ch]. An out-of-range cfg_ch gives cfg_ready=1 and the write is dropped.
  - Accept on cfg_valid&&cfg_ready: shadow[cfg_ch]<=cfg_half, pending<=1.
  - Pending applies at the next terminal count (the toggle cycle): half_q<=shadow, pending<=0. The following half-period uses the new value; the current half-period completes at the old value.
  - Accept in the same cycle as that channel's terminal count: the toggle uses the old half_q; the new value applies at the following terminal.
  - cfg_ready depends only on registered pending and cfg_ch; there is no combinational path from cfg_valid.
- sync=1 (priority over terminal count and en):
  - All channels: count<=0, clk_out<=0, tick<=0.
  - All pending configs are applied.
  - Enabled channels resume counting the cycle after sync drops, so their first rising edge lands exactly eff cycles later, in phase across equal divisors.
- Width rules:
  - count compare is unsigned CNT_W.
  - half_q = 2^CNT_W-1 is legal; no overflow because count is cleared at terminal.
- Reset mid-operation: everything returns to reset values asynchronously, including pending configs (lost) and in-flight half-periods.

Optional Feature:
- Macro CLK_DIV_HOLD_EN.
- Defined: en=0 freezes count, clk_out and the pending state (tick forced 0). Re-enabling resumes mid-period with no phase loss. Pending configs wait for a terminal count or sync.
- Undefined: en=0 behaves as described in Behaviour (clear to 0, apply pending).

Test Plan:
- DEFAULT_HALF=4, NUM_CH=2, both en=1 after reset release -> clk_out toggles every 4 cycles, period 8, tick high 1 cycle at each rise, both channels aligned.
- Write ch1 cfg_half=2 mid-period -> cfg_ready[ch1] low until the next ch1 toggle; that half-period is still 4 cycles, subsequent half-periods are 2; ch0 unchanged.
- cfg_half=0 on ch0 -> after apply, clk_out[0] toggles every cycle and tick fires every 2 cycles.
- Channels with half 3 and 5 running freely, pulse sync 1 cycle -> both clk_out=0 the next cycle; first rises 3 and 5 cycles after sync drops.
- Drop en[0] for 3 cycles at count=2 -> without the macro, clk_out[0]=0 and counting restarts from 0; with CLK_DIV_HOLD_EN, clk_out holds and the period completes 2 cycles after re-enable (half 4).
- Assert reset low mid-period with a pending config -> outputs 0 immediately (before the clock edge); half_q returns to DEFAULT_HALF and the pending write is discarded.
